// File: rtl/io_config_frame_sequencer.sv
// io_config_frame_sequencer
// Sequences single-bit configuration writes from a host (valid/ready) onto an
// I/O tile column. The shared address/data_in bus is set up, the tile's one-hot
// enable is pulsed, and then the bus is held, with programmable cycle counts.
// Ports:
//   prog_clk, pReset_n         clock, async active-low reset
//   cmd_valid/cmd_ready        host handshake
//   cmd_tile/addr/data/last    command payload (last marks end of frame)
//   enable[NUM_IO]             one-hot tile write enable
//   address, data_in           shared config bus
//   busy                       command in flight
//   err                        1-cycle pulse on rejected (out-of-range) tile
//   done                       1-cycle pulse after completing a 'last' write
//   wr_count                   saturating count of completed writes
module io_config_frame_sequencer #(
  parameter int unsigned NUM_IO       = 12,
  parameter int unsigned TILE_W       = 4,
  parameter int unsigned ADDR_W       = 1,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 1,
  parameter int unsigned HOLD_CYCLES  = 1
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [TILE_W-1:0] cmd_tile,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_data,
  input  logic              cmd_last,
  output logic [NUM_IO-1:0] enable,
  output logic [ADDR_W-1:0] address,
  output logic              data_in,
  output logic              busy,
  output logic              err,
  output logic              done,
  output logic [15:0]       wr_count
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WCNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_REJECT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic                last_q, last_d;

  logic                cmd_ready_d;
  logic [NUM_IO-1:0]   enable_d;
  logic [ADDR_W-1:0]   address_d;
  logic                data_in_d;
  logic                busy_d;
  logic                err_d;
  logic                done_d;
  logic [WCNT_W-1:0]   wr_count_d;

  // State, phase counter, latched command and all registered outputs
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tile_q    <= '0;
      last_q    <= 1'b0;
      cmd_ready <= 1'b0;
      enable    <= '0;
      address   <= '0;
      data_in   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      wr_count  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tile_q    <= tile_d;
      last_q    <= last_d;
      cmd_ready <= cmd_ready_d;
      enable    <= enable_d;
      address   <= address_d;
      data_in   <= data_in_d;
      busy      <= busy_d;
      err       <= err_d;
      done      <= done_d;
      wr_count  <= wr_count_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so that the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tile_d     = tile_q;
    last_d     = last_q;
    address_d  = address;
    data_in_d  = data_in;
    wr_count_d = wr_count;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          tile_d = cmd_tile;
          last_d = cmd_last;
          if (32'(cmd_tile) < NUM_IO) begin
            state_d   = S_SETUP;
            cnt_d     = CNT_W'(SETUP_CYCLES - 1);
            address_d = cmd_addr;
            data_in_d = cmd_data;
          end else begin
            state_d = S_REJECT;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_WRITE;
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = last_q;
          if (wr_count != {WCNT_W{1'b1}}) begin
            wr_count_d = wr_count + WCNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_REJECT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    err_d       = (state_d == S_REJECT);

    // One-hot enable for the latched tile only while in WRITE
    enable_d = '0;
    if (state_d == S_WRITE) begin
      for (int unsigned i = 0; i < NUM_IO; i++) begin
        enable_d[i] = (tile_q == TILE_W'(i));
      end
    end
  end

endmodule
